// File: rtl/avm_cmd_master.sv
// avm_cmd_master: drains a small command FIFO into single-word Avalon-MM
// reads/writes towards the synth register slave and returns exactly one
// response per command, in FIFO order.
// Optional feature: define AVM_TIMEOUT_EN to add a waitrequest watchdog that
// abandons a request stalled for TIMEOUT_CYCLES cycles and completes it with
// RSP_ERR = 1. Without it the master waits on waitrequest indefinitely.

module avm_cmd_master #(
   parameter int unsigned ADDR_W         = 6,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned READ_LATENCY   = 1,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              CMD_VALID,
   output logic              CMD_READY,
   input  logic              CMD_WRITE,
   input  logic [ADDR_W-1:0] CMD_ADDR,
   input  logic [DATA_W-1:0] CMD_DATA,
   input  logic [3:0]        CMD_BYTE_EN,
   output logic              RSP_VALID,
   output logic [DATA_W-1:0] RSP_DATA,
   output logic              RSP_ERR,
   output logic              BUSY,
   output logic              AVM_CS,
   output logic              AVM_READ,
   output logic              AVM_WRITE,
   output logic [ADDR_W-1:0] AVM_ADDR,
   output logic [3:0]        AVM_BYTE_EN,
   output logic [DATA_W-1:0] AVM_WRITEDATA,
   input  logic [DATA_W-1:0] AVM_READDATA,
   input  logic              AVM_WAITREQUEST
);

   localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned ENTRY_W = 1 + ADDR_W + DATA_W + 4;
   localparam int unsigned LAT_W   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      RD,
      RD_WAIT,
      DONE
   } state_t;

   state_t state_q, state_d;

   // command FIFO: pointers carry one extra wrap bit so full/empty need no counter
   logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W:0]     wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
   logic               fifo_empty, full_d;
   logic               push, pop;
   logic               cmd_ready_q;

   logic               head_write;
   logic [ADDR_W-1:0]  head_addr;
   logic [DATA_W-1:0]  head_data;
   logic [3:0]         head_be;

   // latched transaction and response
   logic [ADDR_W-1:0]  addr_q;
   logic [3:0]         be_q;
   logic [DATA_W-1:0]  wdata_q;
   logic [DATA_W-1:0]  rsp_data_q;

   logic [LAT_W-1:0]   lat_q;
   logic               lat_last;
   logic               state_change;
   logic               tmo_hit;

   assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
   assign push         = CMD_VALID & cmd_ready_q;
   assign pop          = (state_q == IDLE) & ~fifo_empty;
   assign wr_ptr_d     = wr_ptr_q + {{PTR_W{1'b0}}, push};
   assign rd_ptr_d     = rd_ptr_q + {{PTR_W{1'b0}}, pop};
   // ready is registered from next-cycle occupancy, so a pop while full only
   // reopens the FIFO on the following cycle
   assign full_d       = (wr_ptr_d[PTR_W] != rd_ptr_d[PTR_W]) &&
                         (wr_ptr_d[PTR_W-1:0] == rd_ptr_d[PTR_W-1:0]);
   assign lat_last     = (lat_q == LAT_W'(READ_LATENCY - 1));
   assign state_change = (state_d != state_q);

   // FIFO storage write on accepted command
   always_ff @(posedge CLK) begin
      if (push) begin
         fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {CMD_WRITE, CMD_ADDR, CMD_DATA, CMD_BYTE_EN};
      end
   end

   // split the head entry into its fields
   always_comb begin
      {head_write, head_addr, head_data, head_be} = fifo_mem[rd_ptr_q[PTR_W-1:0]];
   end

   // FIFO pointers and registered ready flag
   always_ff @(posedge CLK) begin
      if (RESET) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cmd_ready_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cmd_ready_q <= ~full_d;
      end
   end

   // FSM state register
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state: issue, wait out waitrequest, wait read latency, respond
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               state_d = head_write ? WR : RD;
            end
         end
         WR: begin
            if (!AVM_WAITREQUEST || tmo_hit) begin
               state_d = DONE;
            end
         end
         RD: begin
            if (!AVM_WAITREQUEST) begin
               state_d = RD_WAIT;
            end else if (tmo_hit) begin
               state_d = DONE;
            end
         end
         RD_WAIT: begin
            if (lat_last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // read latency counter, restarted on every state entry
   always_ff @(posedge CLK) begin
      if (RESET || state_change) begin
         lat_q <= '0;
      end else if (state_q == RD_WAIT) begin
         lat_q <= lat_q + LAT_W'(1);
      end
   end

   // latch the popped command onto the bus registers
   always_ff @(posedge CLK) begin
      if (RESET) begin
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
      end else if (pop) begin
         addr_q  <= head_addr;
         be_q    <= head_be;
         wdata_q <= head_write ? head_data : '0;
      end
   end

   // capture read data on the last latency cycle; cleared for each new command
   always_ff @(posedge CLK) begin
      if (RESET || pop) begin
         rsp_data_q <= '0;
      end else if ((state_q == RD_WAIT) && lat_last) begin
         rsp_data_q <= AVM_READDATA;
      end
   end

`ifdef AVM_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0] tmo_q;
   logic             rsp_err_q;

   assign tmo_hit = ((state_q == WR) || (state_q == RD)) && AVM_WAITREQUEST &&
                    (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

   // waitrequest watchdog, restarted on every state entry
   always_ff @(posedge CLK) begin
      if (RESET || state_change) begin
         tmo_q <= '0;
      end else if (((state_q == WR) || (state_q == RD)) && AVM_WAITREQUEST) begin
         tmo_q <= tmo_q + TMO_W'(1);
      end
   end

   // remember that the current command was abandoned
   always_ff @(posedge CLK) begin
      if (RESET || pop) begin
         rsp_err_q <= 1'b0;
      end else if (tmo_hit) begin
         rsp_err_q <= 1'b1;
      end
   end

   assign RSP_ERR = (state_q == DONE) & rsp_err_q;
`else
   assign tmo_hit = 1'b0;
   assign RSP_ERR = 1'b0;
`endif

   assign CMD_READY     = cmd_ready_q;
   assign RSP_VALID     = (state_q == DONE);
   assign RSP_DATA      = (state_q == DONE) ? rsp_data_q : '0;
   assign BUSY          = ~fifo_empty | (state_q != IDLE);
   assign AVM_CS        = (state_q == WR) | (state_q == RD);
   assign AVM_WRITE     = (state_q == WR);
   assign AVM_READ      = (state_q == RD);
   assign AVM_ADDR      = addr_q;
   assign AVM_BYTE_EN   = be_q;
   assign AVM_WRITEDATA = wdata_q;

endmodule

// File: tb/tb_avm_cmd_master.sv
// Bench for avm_cmd_master: table of single transactions with exact cycle
// timing, hand-written multi-cycle sequences (throughput, backpressure, stall,
// watchdog when AVM_TIMEOUT_EN is defined, reset mid-read) and a random run
// checked by a register-map scoreboard and bus-protocol checks.

module tb_avm_cmd_master;

   localparam int unsigned TMO = 8;
`ifdef AVM_TIMEOUT_EN
   localparam int unsigned STALL_LEN   = 6;
   localparam int unsigned STALL_GUARD = TMO;
`else
   localparam int unsigned STALL_LEN   = 10;
   localparam int unsigned STALL_GUARD = 32'h4000_0000;
`endif

   logic        CLK = 1'b0;
   logic        RESET;
   logic        CMD_VALID, CMD_READY, CMD_WRITE;
   logic [5:0]  CMD_ADDR;
   logic [31:0] CMD_DATA;
   logic [3:0]  CMD_BYTE_EN;
   logic        RSP_VALID, RSP_ERR, BUSY;
   logic [31:0] RSP_DATA;
   logic        AVM_CS, AVM_READ, AVM_WRITE;
   logic [5:0]  AVM_ADDR;
   logic [3:0]  AVM_BYTE_EN;
   logic [31:0] AVM_WRITEDATA, AVM_READDATA;
   logic        AVM_WAITREQUEST;

   avm_cmd_master #(
      .ADDR_W(6),
      .DATA_W(32),
      .FIFO_DEPTH(4),
      .READ_LATENCY(1),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .CLK(CLK),
      .RESET(RESET),
      .CMD_VALID(CMD_VALID),
      .CMD_READY(CMD_READY),
      .CMD_WRITE(CMD_WRITE),
      .CMD_ADDR(CMD_ADDR),
      .CMD_DATA(CMD_DATA),
      .CMD_BYTE_EN(CMD_BYTE_EN),
      .RSP_VALID(RSP_VALID),
      .RSP_DATA(RSP_DATA),
      .RSP_ERR(RSP_ERR),
      .BUSY(BUSY),
      .AVM_CS(AVM_CS),
      .AVM_READ(AVM_READ),
      .AVM_WRITE(AVM_WRITE),
      .AVM_ADDR(AVM_ADDR),
      .AVM_BYTE_EN(AVM_BYTE_EN),
      .AVM_WRITEDATA(AVM_WRITEDATA),
      .AVM_READDATA(AVM_READDATA),
      .AVM_WAITREQUEST(AVM_WAITREQUEST)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        data_err;
      logic [31:0] data;
   } rsp_t;

   typedef struct {
      logic        wr;
      logic [5:0]  addr;
      logic [31:0] data;
      logic [3:0]  be;
      logic [31:0] slv;
      logic [31:0] exp_rsp;
   } vec_t;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned cyc_n    = 0;
   logic [31:0] slave_mem [64];
   logic [31:0] shadow    [64];
   rsp_t        exp_q [$];
   logic        prev_stall = 1'b0;
   int unsigned stall_run  = 0;
   logic [43:0] prev_bus   = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int unsigned b = 0; b < 4; b++) begin
         if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
      end
      return r;
   endfunction

   // checks made on every sampled cycle: protocol rules and response scoreboard
   task automatic observe();
      rsp_t e;
      check("rd_wr_exclusive", {63'd0, AVM_READ & AVM_WRITE}, 64'd0);
      check("cs_follows_ctrl", {63'd0, AVM_CS}, {63'd0, AVM_READ | AVM_WRITE});
      if (prev_stall && stall_run < STALL_GUARD) begin
         check("bus_stable_in_stall",
               {20'd0, AVM_READ, AVM_WRITE, AVM_ADDR, AVM_BYTE_EN, AVM_WRITEDATA},
               {20'd0, prev_bus});
      end
      if (RSP_VALID) begin
         if (exp_q.size() == 0) begin
            check("rsp_unexpected", 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("rsp_data", {32'd0, RSP_DATA}, {32'd0, e.data});
            check("rsp_err", {63'd0, RSP_ERR}, {63'd0, e.data_err});
         end
      end
   endtask

   // one clock: slave and scoreboard bookkeeping, edge, drive read data, observe
   task automatic cyc();
      logic       acc_rd, acc_wr, do_push;
      logic [5:0] rd_addr;
      rsp_t       e;
      acc_rd  = !RESET && AVM_READ && !AVM_WAITREQUEST;
      acc_wr  = !RESET && AVM_WRITE && !AVM_WAITREQUEST;
      do_push = !RESET && CMD_VALID && CMD_READY;
      rd_addr = AVM_ADDR;
      if (acc_wr) slave_mem[AVM_ADDR] = merge(slave_mem[AVM_ADDR], AVM_WRITEDATA, AVM_BYTE_EN);
      if (do_push) begin
         e.data_err = 1'b0;
         if (CMD_WRITE) begin
            e.data = '0;
            shadow[CMD_ADDR] = merge(shadow[CMD_ADDR], CMD_DATA, CMD_BYTE_EN);
         end else begin
            e.data = shadow[CMD_ADDR];
         end
         exp_q.push_back(e);
      end
      if (!RESET && (AVM_READ || AVM_WRITE) && AVM_WAITREQUEST) begin
         prev_stall = 1'b1;
         stall_run++;
      end else begin
         prev_stall = 1'b0;
         stall_run  = 0;
      end
      prev_bus = {AVM_READ, AVM_WRITE, AVM_ADDR, AVM_BYTE_EN, AVM_WRITEDATA};
      if (RESET) exp_q.delete();
      @(posedge CLK);
      #1;
      cyc_n++;
      AVM_READDATA = acc_rd ? slave_mem[rd_addr] : (32'hDEAD_0000 | {16'd0, cyc_n[15:0]});
      observe();
   endtask

   task automatic drive_cmd(input logic wr, input logic [5:0] a, input logic [31:0] d,
                            input logic [3:0] be);
      CMD_VALID   = 1'b1;
      CMD_WRITE   = wr;
      CMD_ADDR    = a;
      CMD_DATA    = d;
      CMD_BYTE_EN = be;
   endtask

   task automatic drain();
      int unsigned w = 0;
      CMD_VALID       = 1'b0;
      AVM_WAITREQUEST = 1'b0;
      while ((exp_q.size() != 0 || BUSY) && w < 300) begin
         cyc();
         w++;
      end
      check("drain_pending", 64'(exp_q.size()), 64'd0);
      check("drain_busy", {63'd0, BUSY}, 64'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_cmd_ready"}, {63'd0, CMD_READY}, 64'd0);
      check({tag, "_rsp_valid"}, {63'd0, RSP_VALID}, 64'd0);
      check({tag, "_rsp_data"},  {32'd0, RSP_DATA}, 64'd0);
      check({tag, "_rsp_err"},   {63'd0, RSP_ERR}, 64'd0);
      check({tag, "_busy"},      {63'd0, BUSY}, 64'd0);
      check({tag, "_avm_ctrl"},  {61'd0, AVM_CS, AVM_READ, AVM_WRITE}, 64'd0);
      check({tag, "_avm_addr"},  {58'd0, AVM_ADDR}, 64'd0);
      check({tag, "_avm_be"},    {60'd0, AVM_BYTE_EN}, 64'd0);
      check({tag, "_avm_wdata"}, {32'd0, AVM_WRITEDATA}, 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      vec_t        tbl [6];
      vec_t        v;
      int unsigned w;
      int unsigned hi_run;
`ifdef AVM_TIMEOUT_EN
      logic [31:0] saved;
      rsp_t        e;
`endif

      tbl[0] = '{1'b1, 6'd7,  32'h0000_1234, 4'hF, 32'h0,         32'h0};
      tbl[1] = '{1'b0, 6'd7,  32'h0,         4'hF, 32'h0000_1234, 32'h0000_1234};
      tbl[2] = '{1'b1, 6'd63, 32'hFFFF_FFFF, 4'h3, 32'h0,         32'h0};
      tbl[3] = '{1'b0, 6'd0,  32'h0,         4'hF, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
      tbl[4] = '{1'b1, 6'd0,  32'h0,         4'h0, 32'h0,         32'h0};
      tbl[5] = '{1'b0, 6'd63, 32'h0,         4'hC, 32'h0000_0000, 32'h0000_0000};

      for (int unsigned i = 0; i < 64; i++) begin
         slave_mem[i] = '0;
         shadow[i]    = '0;
      end
      RESET           = 1'b1;
      CMD_VALID       = 1'b0;
      CMD_WRITE       = 1'b0;
      CMD_ADDR        = '0;
      CMD_DATA        = '0;
      CMD_BYTE_EN     = '0;
      AVM_READDATA    = '0;
      AVM_WAITREQUEST = 1'b0;

      // reset state
      repeat (3) cyc();
      check_all_zero("reset");
      RESET = 1'b0;
      cyc();
      check("ready_after_release", {63'd0, CMD_READY}, 64'd1);

      // single transactions with exact cycle positions relative to the push
      for (int unsigned i = 0; i < 6; i++) begin
         v = tbl[i];
         if (!v.wr) begin
            slave_mem[v.addr] = v.slv;
            shadow[v.addr]    = v.slv;
         end
         drive_cmd(v.wr, v.addr, v.data, v.be);
         check("vec_ready", {63'd0, CMD_READY}, 64'd1);
         cyc();
         CMD_VALID = 1'b0;
         cyc();
         check("vec_ctrl", {61'd0, AVM_CS, AVM_READ, AVM_WRITE}, {61'd0, 1'b1, !v.wr, v.wr});
         check("vec_addr", {58'd0, AVM_ADDR}, {58'd0, v.addr});
         check("vec_be", {60'd0, AVM_BYTE_EN}, {60'd0, v.be});
         if (v.wr) check("vec_wdata", {32'd0, AVM_WRITEDATA}, {32'd0, v.data});
         cyc();
         check("vec_ctrl_drop", {62'd0, AVM_READ, AVM_WRITE}, 64'd0);
         if (!v.wr) begin
            check("vec_rd_no_early_rsp", {63'd0, RSP_VALID}, 64'd0);
            cyc();
         end
         check("vec_rsp_valid", {63'd0, RSP_VALID}, 64'd1);
         check("vec_rsp_data", {32'd0, RSP_DATA}, {32'd0, v.exp_rsp});
         cyc();
         check("vec_rsp_pulse", {63'd0, RSP_VALID}, 64'd0);
         check("vec_idle", {63'd0, BUSY}, 64'd0);
      end

      // back-to-back writes: 3-cycle spacing on the bus
      drive_cmd(1'b1, 6'd3, 32'h33, 4'hF);
      cyc();
      drive_cmd(1'b1, 6'd4, 32'h44, 4'hF);
      cyc();
      CMD_VALID = 1'b0;
      check("tput_wr_a", {63'd0, AVM_WRITE}, 64'd1);
      cyc();
      check("tput_gap1", {63'd0, AVM_WRITE}, 64'd0);
      cyc();
      check("tput_gap2", {63'd0, AVM_WRITE}, 64'd0);
      cyc();
      check("tput_wr_b", {63'd0, AVM_WRITE}, 64'd1);
      check("tput_addr_b", {58'd0, AVM_ADDR}, 64'd4);
      drain();

      // backpressure: one command on the bus plus four queued fill the master
      AVM_WAITREQUEST = 1'b1;
      for (int unsigned i = 0; i < 5; i++) begin
         drive_cmd(1'b1, 6'(8 + i), 32'h100 + i, 4'hF);
         check("bp_accept_ready", {63'd0, CMD_READY}, 64'd1);
         cyc();
      end
      drive_cmd(1'b1, 6'd13, 32'h105, 4'hF);
      for (int unsigned i = 0; i < 2; i++) begin
         check("bp_full_ready", {63'd0, CMD_READY}, 64'd0);
         check("bp_busy", {63'd0, BUSY}, 64'd1);
         cyc();
      end
      AVM_WAITREQUEST = 1'b0;
      w = 0;
      while (!CMD_READY && w < 20) begin
         cyc();
         w++;
      end
      check("bp_ready_returns", {63'd0, CMD_READY}, 64'd1);
      cyc();
      drain();

      // stall: write held by waitrequest keeps its bus values
      AVM_WAITREQUEST = 1'b1;
      drive_cmd(1'b1, 6'h2A, 32'hCAFE_F00D, 4'h5);
      cyc();
      CMD_VALID = 1'b0;
      cyc();
      for (int unsigned i = 0; i < STALL_LEN; i++) begin
         check("stall_write", {63'd0, AVM_WRITE}, 64'd1);
         check("stall_addr", {58'd0, AVM_ADDR}, 64'h2A);
         check("stall_wdata", {32'd0, AVM_WRITEDATA}, 64'hCAFE_F00D);
         cyc();
      end
      check("stall_write_end", {63'd0, AVM_WRITE}, 64'd1);
      AVM_WAITREQUEST = 1'b0;
      cyc();
      check("stall_rsp", {63'd0, RSP_VALID}, 64'd1);
      drain();

`ifdef AVM_TIMEOUT_EN
      // watchdog: stuck write abandoned with an error, next command proceeds
      saved           = shadow[6'h11];
      AVM_WAITREQUEST = 1'b1;
      drive_cmd(1'b1, 6'h11, 32'hA5A5_A5A5, 4'hF);
      cyc();
      e          = exp_q.pop_back();
      e.data_err = 1'b1;
      exp_q.push_back(e);
      shadow[6'h11] = saved;
      drive_cmd(1'b1, 6'h12, 32'h0000_5A5A, 4'hF);
      cyc();
      CMD_VALID = 1'b0;
      for (int unsigned i = 0; i < TMO; i++) begin
         check("tmo_write_held", {63'd0, AVM_WRITE}, 64'd1);
         cyc();
      end
      check("tmo_write_dropped", {63'd0, AVM_WRITE}, 64'd0);
      check("tmo_rsp_valid", {63'd0, RSP_VALID}, 64'd1);
      check("tmo_rsp_err", {63'd0, RSP_ERR}, 64'd1);
      check("tmo_rsp_data", {32'd0, RSP_DATA}, 64'd0);
      AVM_WAITREQUEST = 1'b0;
      cyc();
      cyc();
      check("tmo_next_write", {63'd0, AVM_WRITE}, 64'd1);
      check("tmo_next_addr", {58'd0, AVM_ADDR}, 64'h12);
      drain();
`endif

      // reset while a read is on the bus and two commands are queued
      AVM_WAITREQUEST = 1'b1;
      drive_cmd(1'b0, 6'h20, 32'h0, 4'hF);
      cyc();
      drive_cmd(1'b0, 6'h21, 32'h0, 4'hF);
      cyc();
      drive_cmd(1'b0, 6'h22, 32'h0, 4'hF);
      check("rst_read_active", {63'd0, AVM_READ}, 64'd1);
      cyc();
      CMD_VALID = 1'b0;
      check("rst_read_held", {63'd0, AVM_READ}, 64'd1);
      RESET = 1'b1;
      cyc();
      check_all_zero("rst_mid");
      RESET           = 1'b0;
      AVM_WAITREQUEST = 1'b0;
      cyc();
      check("rst_ready_after", {63'd0, CMD_READY}, 64'd1);
      for (int unsigned i = 0; i < 4; i++) begin
         check("rst_no_rsp", {63'd0, RSP_VALID}, 64'd0);
         check("rst_not_busy", {63'd0, BUSY}, 64'd0);
         cyc();
      end

      // random commands and waitrequest against the register-map scoreboard
      hi_run = 0;
      for (int unsigned c = 0; c < 400; c++) begin
         CMD_VALID   = ($urandom_range(0, 99) < 60);
         CMD_WRITE   = 1'($urandom_range(0, 1));
         CMD_ADDR    = 6'($urandom_range(0, 15));
         CMD_DATA    = $urandom;
         CMD_BYTE_EN = 4'($urandom_range(0, 15));
         if (hi_run >= 4) AVM_WAITREQUEST = 1'b0;
         else AVM_WAITREQUEST = ($urandom_range(0, 99) < 30);
         hi_run = AVM_WAITREQUEST ? hi_run + 1 : 0;
         cyc();
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
